qmax_updater: RTL

Running-maximum update stage placed directly upstream of the Q-max table BRAM. It accepts a stream of (state, candidate Q) pairs, reads the stored Q-max for that state through the table's registered read port, and writes back the larger value. It is fully pipelined at one update per cycle, with forwarding that covers the table's read-before-write hazards. It also provides a sweep mode that clears every table entry to zero.

---
 rtl/qmax_updater.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/qmax_updater.sv
`default_nettype none
// ============================================================================
// Module   : qmax_updater
// Purpose  : Running-maximum update stage in front of a Q-max table BRAM.
//            Each accepted (state, q) pair reads the stored Q-max through
//            the table's registered read port and writes back the larger
//            value. One update per cycle, with S2/S3 forwarding to cover the
//            table's read-before-write hazards. A clear request drains the
//            pipeline and then sweeps every entry to zero.
// Ports    : i_clk, i_rst (async, active-high)
//            i_valid/o_ready/i_state/i_q   candidate stream
//            i_clear                       one-cycle table clear request
//            o_tbl_addr_r/i_tbl_data       table read port (1-cycle latency)
//            o_tbl_addr_w/o_tbl_write_en/o_tbl_data   table write port
//            o_upd_valid/o_upd_state/o_upd_qmax/o_upd_changed   result
//            o_busy, o_write_count         status
// Revision : 1.0  initial release
// ============================================================================
module qmax_updater #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ADDR_WIDTH-1:0] i_state,
  input  logic [DATA_WIDTH-1:0] i_q,
  input  logic                  i_clear,
  output logic [ADDR_WIDTH-1:0] o_tbl_addr_r,
  input  logic [DATA_WIDTH-1:0] i_tbl_data,
  output logic [ADDR_WIDTH-1:0] o_tbl_addr_w,
  output logic                  o_tbl_write_en,
  output logic [DATA_WIDTH-1:0] o_tbl_data,
  output logic                  o_upd_valid,
  output logic [ADDR_WIDTH-1:0] o_upd_state,
  output logic [DATA_WIDTH-1:0] o_upd_qmax,
  output logic                  o_upd_changed,
  output logic                  o_busy,
  output logic [15:0]           o_write_count
);

  localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } fsm_t;

  fsm_t                  r_fsm;
  logic [ADDR_WIDTH-1:0] r_sweep;
  logic [15:0]           r_write_count;

  logic                  r_s1_valid;
  logic [ADDR_WIDTH-1:0] r_s1_state;
  logic [DATA_WIDTH-1:0] r_s1_q;

  logic                  r_s2_valid;
  logic [ADDR_WIDTH-1:0] r_s2_state;
  logic [DATA_WIDTH-1:0] r_s2_qmax;
  logic                  r_s2_changed;

  logic                  r_s3_valid;
  logic [ADDR_WIDTH-1:0] r_s3_state;
  logic [DATA_WIDTH-1:0] r_s3_qmax;

  logic                  w_accept;
  logic                  w_clearing;
  logic                  w_run_write;
  logic [DATA_WIDTH-1:0] w_cur;
  logic                  w_gt;
  logic [DATA_WIDTH-1:0] w_qmax;

  assign o_ready      = (r_fsm == ST_RUN);
  assign o_busy       = (r_fsm != ST_RUN);
  assign w_accept     = i_valid & o_ready;
  // The table is addressed straight from the input; reads that are not
  // accepted simply go unused.
  assign o_tbl_addr_r = i_state;

  // Current stored value for the S1 item. S2 holds the newest value (its
  // write has not committed yet); S3 holds a value whose write committed on
  // the same edge the table sampled this read, so the table returned stale
  // data for it.
  always_comb begin
    w_cur = i_tbl_data;
    if (r_s2_valid && (r_s2_state == r_s1_state)) begin
      w_cur = r_s2_qmax;
    end else if (r_s3_valid && (r_s3_state == r_s1_state)) begin
      w_cur = r_s3_qmax;
    end
  end

  assign w_gt   = (r_s1_q > w_cur);
  assign w_qmax = w_gt ? r_s1_q : w_cur;

  assign w_clearing  = (r_fsm == ST_CLEAR);
  assign w_run_write = r_s2_valid & r_s2_changed;

  assign o_tbl_write_en = w_clearing | w_run_write;
  assign o_tbl_addr_w   = w_clearing ? r_sweep : r_s2_state;
  assign o_tbl_data     = w_clearing ? '0 : r_s2_qmax;

  assign o_upd_valid   = r_s2_valid & ~w_clearing;
  assign o_upd_state   = r_s2_state;
  assign o_upd_qmax    = r_s2_qmax;
  assign o_upd_changed = r_s2_changed;
  assign o_write_count = r_write_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fsm         <= ST_RUN;
      r_sweep       <= '0;
      r_write_count <= '0;
      r_s1_valid    <= 1'b0;
      r_s1_state    <= '0;
      r_s1_q        <= '0;
      r_s2_valid    <= 1'b0;
      r_s2_state    <= '0;
      r_s2_qmax     <= '0;
      r_s2_changed  <= 1'b0;
      r_s3_valid    <= 1'b0;
      r_s3_state    <= '0;
      r_s3_qmax     <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_state <= i_state;
        r_s1_q     <= i_q;
      end

      r_s2_valid   <= r_s1_valid;
      r_s2_state   <= r_s1_state;
      r_s2_qmax    <= w_qmax;
      r_s2_changed <= w_gt;

      r_s3_valid <= r_s2_valid;
      r_s3_state <= r_s2_state;
      r_s3_qmax  <= r_s2_qmax;

      if (w_run_write && (r_write_count != 16'hFFFF)) begin
        r_write_count <= r_write_count + 16'd1;
      end

      case (r_fsm)
        ST_RUN: begin
          if (i_clear) begin
            r_fsm <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Nothing enters S1 while draining, so both stages are empty after
          // this edge exactly when S1 is empty now (S2 takes S1's valid).
          // The last pending write, if any, commits on this same edge.
          if (!r_s1_valid) begin
            r_fsm         <= ST_CLEAR;
            r_s3_valid    <= 1'b0;
            r_write_count <= '0;
          end
        end
        ST_CLEAR: begin
          if (r_sweep == c_last_addr) begin
            r_fsm   <= ST_RUN;
            r_sweep <= '0;
          end else begin
            r_sweep <= r_sweep + 1'b1;
          end
        end
        default: begin
          r_fsm <= ST_RUN;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
